// File: rtl/trivium_stream_gen.sv
// -----------------------------------------------------------------------------
// trivium_stream_gen
//
// Trivium keystream generator that produces W keystream bits per clock. It
// handles its own sequencing: it loads the key and IV, runs the 1152-round
// warm-up, and then streams keystream words over a valid/ready handshake. It
// acts as the DRBG stream source between the seed path and the downstream
// conditioning/packing logic.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset; aborts any session (no done)
//   start      begin a new session (only looked at while IDLE)
//   key        80-bit key, captured on the start-accept edge
//   iv         80-bit IV, captured on the start-accept edge
//   req_words  number of W-bit words to emit, 0 = unlimited; captured with start
//   ks_valid   ks_data holds a keystream word (GEN state)
//   ks_ready   downstream accepts the current word
//   ks_data    keystream word, bit 0 = earliest round
//   busy       session in progress (SETUP or GEN)
//   done       one-cycle pulse after the final requested word is accepted
//
// State bit s(n) of the Trivium description is stored in s_q[n-1].
// -----------------------------------------------------------------------------
module trivium_stream_gen #(
    parameter int W         = 8,
    parameter int KEY_WIDTH = 80,
    parameter int IV_WIDTH  = 80,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic [IV_WIDTH-1:0]  iv,
    input  logic [CNT_WIDTH-1:0] req_words,
    output logic                 ks_valid,
    input  logic                 ks_ready,
    output logic [W-1:0]         ks_data,
    output logic                 busy,
    output logic                 done
);

    // Clamp keeps the derived constants well-defined even when the
    // elaboration check below is about to reject W.
    localparam int W_SAFE      = (W >= 1 && W <= 64) ? W : 1;
    localparam int SETUP_EDGES = 1152 / W_SAFE;
    localparam int SCNT_W      = $clog2(SETUP_EDGES + 1);
    localparam logic [SCNT_W-1:0] SETUP_LAST = SCNT_W'(SETUP_EDGES - 1);

    generate
        if (W < 1 || W > 64 || (1152 % W_SAFE) != 0) begin : g_bad_w
            $error("trivium_stream_gen: W=%0d must be in 1..64 and divide 1152", W);
        end
        if (KEY_WIDTH != 80) begin : g_bad_key
            $error("trivium_stream_gen: KEY_WIDTH=%0d, Trivium needs 80", KEY_WIDTH);
        end
        if (IV_WIDTH != 80) begin : g_bad_iv
            $error("trivium_stream_gen: IV_WIDTH=%0d, Trivium needs 80", IV_WIDTH);
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        GEN   = 2'd2
    } fsm_t;

    fsm_t                 fsm_q, fsm_d;
    logic [287:0]         s_q, s_d;
    logic [SCNT_W-1:0]    setup_cnt_q, setup_cnt_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0] req_q, req_d;
    logic                 done_q, done_d;

    logic [287:0]         s_adv;
    logic [288:0]         rnd;
    logic [W-1:0]         z_bits;
    logic                 accept;
    logic                 last_word;

    // Initial Trivium state: key in s1..s80, IV in s94..s173, ones in s286..s288.
    function automatic logic [287:0] load_state(input logic [KEY_WIDTH-1:0] k,
                                                input logic [IV_WIDTH-1:0]  v);
        logic [287:0] st;
        st           = '0;
        st[79:0]     = k[79:0];
        st[172:93]   = v[79:0];
        st[287:285]  = 3'b111;
        return st;
    endfunction

    // One Trivium round. Returns {z, next_state}.
    function automatic logic [288:0] trivium_round(input logic [287:0] st);
        logic t1, t2, t3, z;
        t1 = st[65]  ^ st[92];
        t2 = st[161] ^ st[176];
        t3 = st[242] ^ st[287];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (st[90]  & st[91])  ^ st[170];
        t2 = t2 ^ (st[174] & st[175]) ^ st[263];
        t3 = t3 ^ (st[285] & st[286]) ^ st[68];
        // Three shift registers: s1..s93 fed by t3, s94..s177 by t1,
        // s178..s288 by t2.
        return {z, st[286:177], t2, st[175:93], t1, st[91:0], t3};
    endfunction

    // W chained rounds from the registered state. With W <= 64 no output bit
    // needs a feedback bit produced within the same cycle, so every z bit
    // is a function of s_q alone.
    always_comb begin
        s_adv  = s_q;
        rnd    = '0;
        z_bits = '0;
        for (int j = 0; j < W; j++) begin
            rnd       = trivium_round(s_adv);
            z_bits[j] = rnd[288];
            s_adv     = rnd[287:0];
        end
    end

    assign ks_valid  = (fsm_q == GEN);
    assign ks_data   = (fsm_q == GEN) ? z_bits : '0;
    assign busy      = (fsm_q != IDLE);
    assign done      = done_q;
    assign accept    = ks_valid & ks_ready;
    // req_q == 0 means unlimited; the explicit guard keeps a wrapped counter
    // from ever matching it.
    assign last_word = (req_q != '0) && (word_cnt_q == (req_q - CNT_WIDTH'(1)));

    always_comb begin
        fsm_d       = fsm_q;
        s_d         = s_q;
        setup_cnt_d = setup_cnt_q;
        word_cnt_d  = word_cnt_q;
        req_d       = req_q;
        done_d      = 1'b0;

        case (fsm_q)
            IDLE: begin
                if (start) begin
                    s_d         = load_state(key, iv);
                    req_d       = req_words;
                    setup_cnt_d = '0;
                    word_cnt_d  = '0;
                    fsm_d       = SETUP;
                end
            end

            SETUP: begin
                s_d = s_adv;
                if (setup_cnt_q == SETUP_LAST) begin
                    setup_cnt_d = '0;
                    fsm_d       = GEN;
                end else begin
                    setup_cnt_d = setup_cnt_q + SCNT_W'(1);
                end
            end

            GEN: begin
                if (accept) begin
                    s_d        = s_adv;
                    word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                    if (last_word) begin
                        // Clear the secret state as the session closes.
                        s_d        = '0;
                        word_cnt_d = '0;
                        done_d     = 1'b1;
                        fsm_d      = IDLE;
                    end
                end
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            s_q         <= '0;
            setup_cnt_q <= '0;
            word_cnt_q  <= '0;
            req_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            s_q         <= s_d;
            setup_cnt_q <= setup_cnt_d;
            word_cnt_q  <= word_cnt_d;
            req_q       <= req_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_trivium_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_trivium_stream_gen
//
// Three generator instances (W=1, W=8, W=64) share one clock and reset. A
// bit-serial Trivium reference written directly from the s1..s288 description
// fills exp_bits; words are compared against it together with directed
// latency, handshake, done and reset expectations.
// Index 0 = W1 (CNT_WIDTH 8), 1 = W8 (CNT_WIDTH 16), 2 = W64 (CNT_WIDTH 3, so
// the unlimited run wraps its word counter).
// -----------------------------------------------------------------------------
module tb_trivium_stream_gen;

    localparam logic [79:0] KEY_A = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] IV_A  = 80'h0F1E2D3C4B5A69788796;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_a;
    logic [2:0]  ready_a;
    logic [2:0]  valid_a;
    logic [2:0]  busy_a;
    logic [2:0]  done_a;
    logic [79:0] key_a [3];
    logic [79:0] iv_a  [3];
    logic [15:0] req_a [3];
    logic [63:0] data_a[3];

    logic [0:0]  d1;
    logic [7:0]  d8;
    logic [63:0] d64;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt[3];

    bit exp_bits[0:2047];

    always #5 clk = ~clk;

    trivium_stream_gen #(.W(1), .KEY_WIDTH(80), .IV_WIDTH(80), .CNT_WIDTH(8)) u_w1 (
        .clk(clk), .rst(rst), .start(start_a[0]), .key(key_a[0]), .iv(iv_a[0]),
        .req_words(req_a[0][7:0]), .ks_valid(valid_a[0]), .ks_ready(ready_a[0]),
        .ks_data(d1), .busy(busy_a[0]), .done(done_a[0])
    );

    trivium_stream_gen #(.W(8), .KEY_WIDTH(80), .IV_WIDTH(80), .CNT_WIDTH(16)) u_w8 (
        .clk(clk), .rst(rst), .start(start_a[1]), .key(key_a[1]), .iv(iv_a[1]),
        .req_words(req_a[1]), .ks_valid(valid_a[1]), .ks_ready(ready_a[1]),
        .ks_data(d8), .busy(busy_a[1]), .done(done_a[1])
    );

    trivium_stream_gen #(.W(64), .KEY_WIDTH(80), .IV_WIDTH(80), .CNT_WIDTH(3)) u_w64 (
        .clk(clk), .rst(rst), .start(start_a[2]), .key(key_a[2]), .iv(iv_a[2]),
        .req_words(req_a[2][2:0]), .ks_valid(valid_a[2]), .ks_ready(ready_a[2]),
        .ks_data(d64), .busy(busy_a[2]), .done(done_a[2])
    );

    assign data_a[0] = {63'd0, d1};
    assign data_a[1] = {56'd0, d8};
    assign data_a[2] = d64;

    // done is registered, so its value just before an edge is the pulse of
    // the cycle that edge closes.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done_a[d]) done_cnt[d] <= done_cnt[d] + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int d);
        case (d)
            0:       return 1;
            1:       return 8;
            default: return 64;
        endcase
    endfunction

    // Bit-serial Trivium, 1-based indexing as in the algorithm description.
    task automatic model_run(input logic [79:0] k, input logic [79:0] v, input int nbits);
        bit s[1:288];
        bit t1, t2, t3, z;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[i-1];
            s[93 + i] = v[i-1];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int r = 0; r < 1152 + nbits; r++) begin
            t1 = s[66]  ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91]  & s[92])  ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 288; i >= 2; i--) s[i] = s[i-1];
            s[1]   = t3;
            s[94]  = t1;
            s[178] = t2;
            if (r >= 1152) exp_bits[r - 1152] = z;
        end
    endtask

    function automatic logic [63:0] exp_word(input int w, input int idx);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < w; j++) r[j] = exp_bits[idx * w + j];
        return r;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the
    // start-accept edge.
    task automatic do_start(input int d, input logic [79:0] k, input logic [79:0] v,
                            input logic [15:0] req);
        key_a[d]   = k;
        iv_a[d]    = v;
        req_a[d]   = req;
        start_a[d] = 1'b1;
        @(negedge clk);
        start_a[d] = 1'b0;
    endtask

    // Counts edges from the accept edge (inclusive) until ks_valid is seen,
    // and the cycles spent busy without valid.
    task automatic measure_setup(input int d, input int exp_edges, input int exp_setup);
        int edges;
        int sc;
        bit leak;
        edges = 1;
        sc    = 0;
        leak  = 1'b0;
        while (!valid_a[d] && edges < 2000) begin
            if (busy_a[d]) sc++;
            if (data_a[d] != 64'd0) leak = 1'b1;
            @(negedge clk);
            edges++;
        end
        check_val($sformatf("setup_edges_d%0d", d), 64'(edges), 64'(exp_edges));
        check_val($sformatf("setup_cycles_d%0d", d), 64'(sc), 64'(exp_setup));
        check_val($sformatf("setup_data_zero_d%0d", d), 64'(leak), 64'd0);
    endtask

    // Accepts n words with ks_ready high duty% of the time, comparing each
    // accepted word to the model and checking data holds across stalls.
    task automatic collect(input int d, input int n, input int duty, input int base);
        int got;
        int cyc;
        bit rdy;
        bit prev_stall;
        logic [63:0] prev_data;
        got        = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (got < n && cyc < 5000) begin
            rdy = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            if (prev_stall)
                check_val($sformatf("stall_hold_d%0d_w%0d", d, base + got), data_a[d], prev_data);
            if (valid_a[d] && rdy) begin
                check_val($sformatf("word_d%0d_w%0d", d, base + got), data_a[d],
                          exp_word(width_of(d), base + got));
                got++;
            end
            prev_stall = valid_a[d] && !rdy;
            prev_data  = data_a[d];
            ready_a[d] = rdy;
            @(negedge clk);
            cyc++;
        end
        ready_a[d] = 1'b0;
        if (got < n) check_val($sformatf("collect_timeout_d%0d", d), 64'(got), 64'(n));
    endtask

    task automatic check_done_now(input int d, input string tag);
        check_val({tag, "_done"},  64'(done_a[d]),  64'd1);
        check_val({tag, "_busy"},  64'(busy_a[d]),  64'd0);
        check_val({tag, "_valid"}, 64'(valid_a[d]), 64'd0);
    endtask

    task automatic check_all_zero(input int d, input string tag);
        check_val({tag, "_valid"}, 64'(valid_a[d]), 64'd0);
        check_val({tag, "_data"},  data_a[d],       64'd0);
        check_val({tag, "_busy"},  64'(busy_a[d]),  64'd0);
        check_val({tag, "_done"},  64'(done_a[d]),  64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors",
                 n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        rst     = 1'b1;
        start_a = '0;
        ready_a = '0;
        for (int d = 0; d < 3; d++) begin
            key_a[d]    = '0;
            iv_a[d]     = '0;
            req_a[d]    = '0;
            done_cnt[d] = 0;
        end

        // Reset state of every instance.
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) check_all_zero(d, $sformatf("reset_d%0d", d));
        rst = 1'b0;
        @(negedge clk);

        // W=1, zero key and IV, 64 bits: 1152 warm-up edges.
        model_run(80'd0, 80'd0, 64);
        do_start(0, 80'd0, 80'd0, 16'd64);
        measure_setup(0, 1153, 1152);
        collect(0, 64, 100, 0);
        check_done_now(0, "w1_end");
        @(negedge clk);
        check_val("w1_done_one_cycle", 64'(done_a[0]), 64'd0);

        // W=8 and W=64 on the same key/IV must produce the same bit stream.
        model_run(KEY_A, IV_A, 1280);
        do_start(1, KEY_A, IV_A, 16'd16);
        measure_setup(1, 145, 144);
        collect(1, 16, 100, 0);
        check_done_now(1, "w8_end");
        @(negedge clk);

        do_start(2, KEY_A, IV_A, 16'd2);
        measure_setup(2, 19, 18);
        collect(2, 2, 100, 0);
        check_done_now(2, "w64_end");
        @(negedge clk);

        // Backpressure at 30% ready duty.
        do_start(1, KEY_A, IV_A, 16'd16);
        measure_setup(1, 145, 144);
        collect(1, 16, 30, 0);
        check_done_now(1, "w8_bp_end");
        @(negedge clk);

        // req_words=3, then restart in the done cycle.
        repeat (2) @(negedge clk);
        dc = done_cnt[1];
        do_start(1, KEY_A, IV_A, 16'd3);
        measure_setup(1, 145, 144);
        collect(1, 3, 100, 0);
        check_done_now(1, "w8_req3_end");
        do_start(1, KEY_A, IV_A, 16'd3);
        check_val("b2b_done_cleared", 64'(done_a[1]), 64'd0);
        check_val("b2b_busy", 64'(busy_a[1]), 64'd1);
        measure_setup(1, 145, 144);
        collect(1, 3, 100, 0);
        check_done_now(1, "b2b_end");
        repeat (2) @(negedge clk);
        check_val("b2b_done_pulses", 64'(done_cnt[1] - dc), 64'd2);

        // Reset in SETUP, then in GEN: no done, outputs cleared.
        dc = done_cnt[1];
        do_start(1, KEY_A, IV_A, 16'd16);
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero(1, "rst_setup");
        do_start(1, KEY_A, IV_A, 16'd16);
        measure_setup(1, 145, 144);
        collect(1, 2, 100, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero(1, "rst_gen");
        repeat (2) @(negedge clk);
        check_val("rst_no_done", 64'(done_cnt[1] - dc), 64'd0);
        do_start(1, KEY_A, IV_A, 16'd1);
        measure_setup(1, 145, 144);
        collect(1, 1, 100, 0);
        check_done_now(1, "rst_restart_end");
        repeat (2) @(negedge clk);
        check_val("rst_restart_done_pulses", 64'(done_cnt[1] - dc), 64'd1);

        // Unlimited session on the 3-bit counter instance: wraps twice,
        // ignores start in GEN, never signals done.
        dc = done_cnt[2];
        do_start(2, KEY_A, IV_A, 16'd0);
        measure_setup(2, 19, 18);
        collect(2, 10, 100, 0);
        start_a[2] = 1'b1;
        @(negedge clk);
        start_a[2] = 1'b0;
        check_val("unl_start_ignored_busy", 64'(busy_a[2]), 64'd1);
        check_val("unl_start_ignored_valid", 64'(valid_a[2]), 64'd1);
        collect(2, 10, 100, 10);
        repeat (3) @(negedge clk);
        check_val("unl_no_done", 64'(done_cnt[2] - dc), 64'd0);
        check_val("unl_still_busy", 64'(busy_a[2]), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero(2, "unl_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
